// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU: registered single-cycle ops plus iterative
// MULT/MULTU/DIV/DIVU with HI/LO and a start/busy/done handshake.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [5:0]               func,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic [WIDTH-1:0]         result,
    output logic                     z_flag,
    output logic                     ovf,
    output logic                     dz,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         hi,
    output logic [WIDTH-1:0]         lo
);
    localparam int W = WIDTH;
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] ONE_S = SHW'(1);
    localparam logic [W-1:0] ONE_W = W'(1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state_q, state_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [W-1:0] x_q, x_d;
    logic [2*W-1:0] p_q, p_d;
    logic negq_q, negq_d, negr_q, negr_d;
    logic [W-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic z_q, z_d, ovf_q, ovf_d, dz_q, dz_d;
    logic busy_q, busy_d, done_q, done_d;

    logic [W:0] msum, dsh, dtr;
    logic [2*W-1:0] pstep;
    logic [W-1:0] fin_hi, fin_lo;
    logic [W-1:0] res_n, sum, diff, ma, mb;
    logic is_br, z_br, multi, sgn;

    function automatic logic [W-1:0] lead(input logic [W-1:0] v, input logic ones);
        logic [W-1:0] n;
        logic stop;
        n = '0;
        stop = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!stop && v[i] == ones) n = n + ONE_W;
            else stop = 1'b1;
        end
        return n;
    endfunction

    // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        msum = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, x_q} : '0);
        dsh = {p_q[2*W-1:W], p_q[W-1]};
        dtr = dsh - {1'b0, x_q};
        if (state_q == S_MUL) begin
            pstep = {msum, p_q[W-1:1]};
            {fin_hi, fin_lo} = negq_q ? -pstep : pstep;
        end else begin
            pstep = dtr[W] ? {dsh[W-1:0], p_q[W-2:0], 1'b0}
                           : {dtr[W-1:0], p_q[W-2:0], 1'b1};
            fin_lo = negq_q ? -pstep[W-1:0] : pstep[W-1:0];
            fin_hi = negr_q ? -pstep[2*W-1:W] : pstep[2*W-1:W];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        x_d = x_q;
        p_d = p_q;
        negq_d = negq_q;
        negr_d = negr_q;
        result_d = result_q;
        z_d = z_q;
        ovf_d = ovf_q;
        dz_d = dz_q;
        hi_d = hi_q;
        lo_d = lo_q;
        busy_d = 1'b0;
        done_d = 1'b0;
        sum = a + b;
        diff = a - b;
        res_n = '0;
        is_br = 1'b0;
        z_br = 1'b0;
        multi = 1'b0;
        sgn = ~func[0];
        ma = (sgn && a[W-1]) ? -a : a;
        mb = (sgn && b[W-1]) ? -b : b;
        unique case (state_q)
            S_MUL, S_DIV: begin
                busy_d = 1'b1;
                p_d = pstep;
                cnt_d = cnt_q + ONE_S;
                if (cnt_q == LAST) begin
                    hi_d = fin_hi;
                    lo_d = fin_lo;
                    result_d = fin_lo;
                    z_d = (fin_lo == '0);
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    ovf_d = 1'b0;
                    dz_d = 1'b0;
                    done_d = 1'b1;
                    case (func)
                        6'b100100: res_n = a & b;
                        6'b100101: res_n = a | b;
                        6'b100110: res_n = a ^ b;
                        6'b100111: res_n = ~(a | b);
                        6'b100001: res_n = sum;
                        6'b100011: res_n = diff;
                        6'b100000: begin
                            res_n = sum;
                            ovf_d = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
                        end
                        6'b100010: begin
                            res_n = diff;
                            ovf_d = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
                        end
                        6'b000000: res_n = a << shamt;
                        6'b000010: res_n = a >> shamt;
                        6'b000011: res_n = $signed(a) >>> shamt;
                        6'b000100: res_n = a << b[SHW-1:0];
                        6'b000110: res_n = a >> b[SHW-1:0];
                        6'b101010: res_n = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
                        6'b101011: res_n = {{(W-1){1'b0}}, a < b};
                        6'b111000: res_n = lead(a, 1'b1);
                        6'b000111: res_n = lead(a, 1'b0);
                        6'b010000: res_n = hi_q;
                        6'b010010: res_n = lo_q;
                        6'b010001: begin
                            hi_d = a;
                            res_n = a;
                        end
                        6'b010011: begin
                            lo_d = a;
                            res_n = a;
                        end
                        6'b110010: begin
                            is_br = 1'b1;
                            z_br = !a[W-1] && (a != '0);
                        end
                        6'b110110: begin
                            is_br = 1'b1;
                            z_br = a[W-1] || (a == '0);
                        end
                        6'b110100: begin
                            is_br = 1'b1;
                            z_br = 1'b1;
                        end
                        6'b011000, 6'b011001: begin
                            multi = 1'b1;
                            x_d = ma;
                            p_d = {{W{1'b0}}, mb};
                            negq_d = sgn && (a[W-1] ^ b[W-1]);
                            state_d = S_MUL;
                        end
                        6'b011010, 6'b011011: begin
                            if (b == '0) begin
                                dz_d = 1'b1;
                                lo_d = '1;
                                hi_d = a;
                                res_n = '1;
                            end else begin
                                multi = 1'b1;
                                x_d = mb;
                                p_d = {{W{1'b0}}, ma};
                                negq_d = sgn && (a[W-1] ^ b[W-1]);
                                negr_d = sgn && a[W-1];
                                state_d = S_DIV;
                            end
                        end
                        default: res_n = '0;
                    endcase
                    if (multi) begin
                        cnt_d = '0;
                        busy_d = 1'b1;
                        done_d = 1'b0;
                    end else if (is_br) begin
                        z_d = z_br;
                    end else begin
                        result_d = res_n;
                        z_d = (res_n == '0);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            x_q <= '0;
            p_q <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            result_q <= '0;
            z_q <= 1'b0;
            ovf_q <= 1'b0;
            dz_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            x_q <= x_d;
            p_q <= p_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            result_q <= result_d;
            z_q <= z_d;
            ovf_q <= ovf_d;
            dz_q <= dz_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign result = result_q;
    assign z_flag = z_q;
    assign ovf = ovf_q;
    assign dz = dz_q;
    assign busy = busy_q;
    assign done = done_q;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: vector table, multi-cycle corner sequences,
// then random ops against an arithmetic reference model.
module tb_alu_multicycle;
    logic clk = 1'b0;
    logic reset, start;
    logic [5:0] func;
    logic [31:0] a, b;
    logic [4:0] shamt;
    logic [31:0] result, hi, lo;
    logic z_flag, ovf, dz, busy, done;

    int nvec = 0;
    int nbad = 0;
    logic [31:0] m_hi, m_lo, m_res;

    localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011, F_AND = 6'b100100, F_OR = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110, F_NOR = 6'b100111, F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010, F_SRA = 6'b000011, F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110, F_SLT = 6'b101010, F_SLTU = 6'b101011;
    localparam logic [5:0] F_CLO = 6'b111000, F_CLZ = 6'b000111, F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010, F_MTHI = 6'b010001, F_MTLO = 6'b010011;
    localparam logic [5:0] F_BGTZ = 6'b110010, F_BLEZ = 6'b110110, F_B = 6'b110100;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV = 6'b011010, F_DIVU = 6'b011011;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .func(func),
        .a(a), .b(b), .shamt(shamt), .result(result), .z_flag(z_flag),
        .ovf(ovf), .dz(dz), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] f;
        logic [31:0] a, b;
        logic [4:0] sh;
        logic [31:0] r;
        logic z, o;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic [5:0] f, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [4:0] sh, input bit poke, output int lat, output int bsy);
        bit both;
        both = 1'b0;
        @(negedge clk);
        func = f; a = ia; b = ib; shamt = sh; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; shamt = 5'($urandom);
        lat = 1;
        bsy = 0;
        while (!done && lat < 100) begin
            if (busy) bsy++;
            if (poke && lat == 5) begin
                start = 1'b1; func = F_DIV; a = 32'd100; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (busy && done) both = 1'b1;
        chk("busy_done_exclusive", 32'(both), 32'd0);
        if (lat >= 100) chk("timeout_waiting_done", 32'(lat), 32'd0);
    endtask

    task automatic model(input logic [5:0] f, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [4:0] sh, output logic [31:0] er, output logic ez,
                         output logic eo, output logic ed, output int elat);
        longint s, q, rr;
        logic [63:0] p;
        int n;
        bit br;
        er = '0; ez = 1'b0; eo = 1'b0; ed = 1'b0; elat = 1; br = 1'b0; n = 0;
        case (f)
            F_AND: er = ia & ib;
            F_OR: er = ia | ib;
            F_XOR: er = ia ^ ib;
            F_NOR: er = ~(ia | ib);
            F_ADDU: er = ia + ib;
            F_SUBU: er = ia - ib;
            F_ADD, F_SUB: begin
                if (f == F_ADD) s = longint'($signed(ia)) + longint'($signed(ib));
                else s = longint'($signed(ia)) - longint'($signed(ib));
                er = s[31:0];
                eo = (s != longint'($signed(er)));
            end
            F_SLL: er = ia << sh;
            F_SRL: er = ia >> sh;
            F_SRA: er = $signed(ia) >>> sh;
            F_SLLV: er = ia << ib[4:0];
            F_SRLV: er = ia >> ib[4:0];
            F_SLT: er = ($signed(ia) < $signed(ib)) ? 32'd1 : 32'd0;
            F_SLTU: er = (ia < ib) ? 32'd1 : 32'd0;
            F_CLO: begin
                for (int i = 31; i >= 0 && ia[i]; i--) n++;
                er = 32'(n);
            end
            F_CLZ: begin
                for (int i = 31; i >= 0 && !ia[i]; i--) n++;
                er = 32'(n);
            end
            F_MFHI: er = m_hi;
            F_MFLO: er = m_lo;
            F_MTHI: begin m_hi = ia; er = ia; end
            F_MTLO: begin m_lo = ia; er = ia; end
            F_BGTZ: begin br = 1'b1; ez = ($signed(ia) > 0); end
            F_BLEZ: begin br = 1'b1; ez = ($signed(ia) <= 0); end
            F_B: begin br = 1'b1; ez = 1'b1; end
            F_MULT, F_MULTU: begin
                if (f == F_MULT) p = 64'(longint'($signed(ia)) * longint'($signed(ib)));
                else p = {32'd0, ia} * {32'd0, ib};
                m_hi = p[63:32]; m_lo = p[31:0]; er = m_lo; elat = 33;
            end
            F_DIV, F_DIVU: begin
                if (ib == 0) begin
                    ed = 1'b1; m_lo = '1; m_hi = ia; er = m_lo;
                end else begin
                    if (f == F_DIV) begin
                        q = longint'($signed(ia)) / longint'($signed(ib));
                        rr = longint'($signed(ia)) % longint'($signed(ib));
                        m_lo = q[31:0]; m_hi = rr[31:0];
                    end else begin
                        m_lo = ia / ib; m_hi = ia % ib;
                    end
                    er = m_lo; elat = 33;
                end
            end
            default: er = '0;
        endcase
        if (br) er = m_res;
        else ez = (er == 0);
        m_res = er;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t tbl[$];
        logic [5:0] codes[28];
        int lat, bsy, elat;
        logic [31:0] er, ia, ib;
        logic ez, eo, ed;
        logic [5:0] f;
        logic [4:0] sh;

        codes = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLL, F_SRL,
                  F_SRA, F_SLLV, F_SRLV, F_SLT, F_SLTU, F_CLO, F_CLZ, F_MFHI, F_MFLO,
                  F_MTHI, F_MTLO, F_BGTZ, F_BLEZ, F_B, F_MULT, F_MULTU, F_DIV, F_DIVU};

        tbl.push_back('{F_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1});
        tbl.push_back('{F_SUB, 32'h5, 32'h5, 5'd0, 32'h0, 1'b1, 1'b0});
        tbl.push_back('{F_CLZ, 32'h0, 32'h0, 5'd0, 32'd32, 1'b0, 1'b0});
        tbl.push_back('{F_CLO, 32'hFFFF_FFFF, 32'h0, 5'd0, 32'd32, 1'b0, 1'b0});
        tbl.push_back('{F_CLZ, 32'h0001_0000, 32'h0, 5'd0, 32'd15, 1'b0, 1'b0});
        tbl.push_back('{F_SRA, 32'h8000_0000, 32'h0, 5'd4, 32'hF800_0000, 1'b0, 1'b0});
        tbl.push_back('{F_BLEZ, 32'h8000_0000, 32'h0, 5'd0, 32'hF800_0000, 1'b1, 1'b0});
        tbl.push_back('{F_BGTZ, 32'h8000_0000, 32'h0, 5'd0, 32'hF800_0000, 1'b0, 1'b0});
        tbl.push_back('{F_B, 32'h0, 32'h0, 5'd0, 32'hF800_0000, 1'b1, 1'b0});
        tbl.push_back('{F_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0});
        tbl.push_back('{F_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0});
        tbl.push_back('{F_NOR, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0});
        tbl.push_back('{F_SLLV, 32'h1, 32'h23, 5'd0, 32'h8, 1'b0, 1'b0});
        tbl.push_back('{F_SRLV, 32'h8000_0000, 32'h3F, 5'd0, 32'h1, 1'b0, 1'b0});
        tbl.push_back('{F_SUB, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1});
        tbl.push_back('{F_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b0});
        tbl.push_back('{6'b111111, 32'h5, 32'h5, 5'd0, 32'h0, 1'b1, 1'b0});
        tbl.push_back('{F_SLL, 32'h3, 32'h0, 5'd31, 32'h8000_0000, 1'b0, 1'b0});
        tbl.push_back('{F_XOR, 32'hF0F0, 32'hFF00, 5'd0, 32'h0FF0, 1'b0, 1'b0});

        reset = 1'b1; start = 1'b0; func = '0; a = '0; b = '0; shamt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy_done", {30'd0, busy, done}, 32'h0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            do_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].sh, 1'b0, lat, bsy);
            chk($sformatf("tbl%0d_result", i), result, tbl[i].r);
            chk($sformatf("tbl%0d_z", i), 32'(z_flag), 32'(tbl[i].z));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].o));
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd1);
        end

        // back-to-back single-cycle starts
        @(negedge clk);
        func = F_ADDU; a = 32'd1; b = 32'd2; start = 1'b1;
        @(negedge clk);
        chk("b2b_first", result, 32'd3);
        chk("b2b_first_done", 32'(done), 32'd1);
        a = 32'd10; b = 32'd20;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second", result, 32'd30);
        chk("b2b_second_done", 32'(done), 32'd1);

        do_op(F_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0, lat, bsy);
        chk("mult_latency", 32'(lat), 32'd33);
        chk("mult_busy_cycles", 32'(bsy), 32'd32);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        chk("mult_result", result, 32'hFFFF_FFFA);
        do_op(F_MULTU, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0, lat, bsy);
        chk("multu_latency", 32'(lat), 32'd33);
        chk("multu_hi", hi, 32'h2);
        chk("multu_lo", lo, 32'hFFFF_FFFA);
        do_op(F_MFHI, 32'h0, 32'h0, 5'd0, 1'b0, lat, bsy);
        chk("mfhi_after_multu", result, 32'h2);
        do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0, lat, bsy);
        chk("div_latency", 32'(lat), 32'd33);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_dz", 32'(dz), 32'd0);
        do_op(F_DIV, 32'h0000_1234, 32'd0, 5'd0, 1'b0, lat, bsy);
        chk("div0_latency", 32'(lat), 32'd1);
        chk("div0_dz", 32'(dz), 32'd1);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'h0000_1234);
        do_op(F_MTLO, 32'hCAFE_0001, 32'h0, 5'd0, 1'b0, lat, bsy);
        do_op(F_MFLO, 32'h0, 32'h0, 5'd0, 1'b0, lat, bsy);
        chk("mtlo_mflo", result, 32'hCAFE_0001);
        chk("mtlo_keeps_hi", hi, 32'h0000_1234);
        do_op(F_MULTU, 32'd5, 32'd7, 5'd0, 1'b1, lat, bsy);
        chk("poke_latency", 32'(lat), 32'd33);
        chk("poke_lo", lo, 32'd35);
        chk("poke_hi", hi, 32'd0);

        // reset in the middle of a division
        @(negedge clk);
        func = F_DIV; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy_done", {30'd0, busy, done}, 32'h0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0; m_res = '0;
        model(F_MULTU, 32'd3, 32'd4, 5'd0, er, ez, eo, ed, elat);
        do_op(F_MULTU, 32'd3, 32'd4, 5'd0, 1'b0, lat, bsy);
        chk("rst_then_multu_lo", lo, 32'd12);
        chk("rst_then_multu_model", result, er);

        for (int k = 0; k < 150; k++) begin
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : codes[$urandom_range(0, 27)];
            ia = rnd_opnd();
            ib = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_opnd();
            sh = 5'($urandom);
            model(f, ia, ib, sh, er, ez, eo, ed, elat);
            do_op(f, ia, ib, sh, 1'b0, lat, bsy);
            chk($sformatf("rnd%0d_f%b_result", k, f), result, er);
            chk($sformatf("rnd%0d_f%b_z", k, f), 32'(z_flag), 32'(ez));
            chk($sformatf("rnd%0d_f%b_ovf", k, f), 32'(ovf), 32'(eo));
            chk($sformatf("rnd%0d_f%b_dz", k, f), 32'(dz), 32'(ed));
            chk($sformatf("rnd%0d_f%b_hi", k, f), hi, m_hi);
            chk($sformatf("rnd%0d_f%b_lo", k, f), lo, m_lo);
            chk($sformatf("rnd%0d_f%b_latency", k, f), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_f%b_busy", k, f), 32'(bsy), 32'(elat - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
